serial_adder_controller: RTL and testbench
==========================================

// Module: serial_adder_controller
// PURPOSE
//  Sequencing control unit for the 64-bit digit-serial adder datapath (4 bits/clk).
//  Converts one start request into operand load, carry/result clear, a fixed count of
//  digit-shift cycles and a sticky done flag. Drives the datapath's enb*/load*/zero* strobes.
// PARAMETERS
//  WIDTH   64  operand/result width in bits
//  DIGIT    4  bits added per shift cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise)
//  STEPS   WIDTH/DIGIT (16)  shift cycles per addition (localparam, not overridable)
// PORTS
//  clk    in  1  system clock, rising edge
//  rst    in  1  asynchronous, active-low reset
//  start  in  1  level request; one addition per high level (re-arms only after start low)
//  loadA  out 1  parallel-load operand register A from dA
//  loadB  out 1  parallel-load operand register B from dB
//  zeroA  out 1  clear operand register A
//  zeroB  out 1  clear operand register B
//  zeroR  out 1  clear result shift register
//  zeroD  out 1  clear carry flop
//  enbA   out 1  shift A right by DIGIT
//  enbB   out 1  shift B right by DIGIT
//  enbR   out 1  shift DIGIT sum bits into result register
//  loadR  out 1  capture digit carry-out into carry flop
//  done   out 1  result/carryOut valid; sticky
// BEHAVIOUR
//  Reset: rst=0 -> state IDLE, step counter 0, done 0, all strobes 0, immediately (async).
//  Strobes are Moore outputs decoded from the state register only; no start->strobe path.
//  States / transitions (one per clk):
//   IDLE   : no strobes. start=1 -> INIT, done<=0. start=0 -> stay, done holds.
//   INIT   : loadA=loadB=zeroR=zeroD=1 for exactly one cycle; counter<=0 -> SHIFT.
//   SHIFT  : enbA=enbB=enbR=loadR=1 every cycle; counter++.
//            counter==STEPS-1 -> FINISH (exactly STEPS cycles in SHIFT).
//   FINISH : zeroA=zeroB=1 for one cycle; done<=1 -> start ? HOLD : IDLE.
//   HOLD   : no strobes, done stays 1; start=0 -> IDLE. Prevents relaunch on held start.
//  Latency: start sampled high in IDLE at edge N -> INIT N+1, SHIFT N+2..N+17,
//   FINISH N+18, done=1 visible after edge N+19 (STEPS+3 edges).
//  done: cleared on the edge leaving IDLE for INIT; otherwise holds until reset.
//  start in INIT/SHIFT/FINISH is ignored; deassertion does not abort an addition.
//  Never two load/zero/shift strobes for the same register in one cycle
//   (loadA vs zeroA vs enbA mutually exclusive; same for B, R).
//  Counter width = clog2(STEPS); saturation impossible, wraps only by reload in INIT.
//  Reset mid-addition: abort at once, done 0; datapath contents undefined until next INIT.
//  Illegal/unused state encodings -> IDLE on next edge, strobes 0.
// TESTING
//  1. Reset: rst=0 in any state -> all outputs 0 same cycle; rst=1, start=0 -> IDLE, done 0.
//  2. Single op: 1-cycle start pulse -> INIT 1 cyc, enbA/B/R+loadR high exactly 16 cyc,
//     zeroA/B 1 cyc, done=1 at edge 19; with datapath dA=FFFF_FFFF_FFFF_FFFF, dB=1
//     -> result 0, carryOut 1.
//  3. Held start: start high 40 cycles -> exactly one addition (16 shifts), done stays 1,
//     IDLE only after start drops; second pulse clears done and runs again.
//  4. Back-to-back: start low 1 cyc after done, then high -> done 0 next edge, new op
//     with dA=0123_4567_89AB_CDEF, dB=1111_1111_1111_1111 -> result 1234_5678_9ABC_DF00, carry 0.
//  5. Mid-op reset: rst=0 at 8th SHIFT cycle -> strobes 0 immediately, done 0; restart
//     gives full 16-shift sequence and correct sum.
//  6. Strobe exclusivity assertion enabled throughout all scenarios; zero violations.

Source files
------------

// File: rtl/serial_adder_controller.sv
// Sequencing controller for the digit-serial adder datapath.
// One start request becomes: operand load with result/carry clear, STEPS
// digit-shift cycles, operand clear, and a sticky done flag. All strobes are
// decoded from the state register only.
module serial_adder_controller #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic loadA,
    output logic loadB,
    output logic zeroA,
    output logic zeroB,
    output logic zeroR,
    output logic zeroD,
    output logic enbA,
    output logic enbB,
    output logic enbR,
    output logic loadR,
    output logic done
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if ((DIGIT <= 0) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_adder_controller: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SHIFT  = 3'd2,
        FINISH = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          done_next;

    // State, step counter and sticky done flag; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    // Next-state, counter and Moore strobe decode.
    always_comb begin
        state_next = IDLE;
        cnt_next   = cnt;
        done_next  = done;
        loadA      = 1'b0;
        loadB      = 1'b0;
        zeroA      = 1'b0;
        zeroB      = 1'b0;
        zeroR      = 1'b0;
        zeroD      = 1'b0;
        enbA       = 1'b0;
        enbB       = 1'b0;
        enbR       = 1'b0;
        loadR      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                    done_next  = 1'b0;
                end else begin
                    state_next = IDLE;
                end
            end
            INIT: begin
                loadA      = 1'b1;
                loadB      = 1'b1;
                zeroR      = 1'b1;
                zeroD      = 1'b1;
                cnt_next   = '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                enbA     = 1'b1;
                enbB     = 1'b1;
                enbR     = 1'b1;
                loadR    = 1'b1;
                cnt_next = cnt + 1'b1;
                state_next = (cnt == LAST) ? FINISH : SHIFT;
            end
            FINISH: begin
                zeroA      = 1'b1;
                zeroB      = 1'b1;
                done_next  = 1'b1;
                state_next = start ? HOLD : IDLE;
            end
            HOLD: begin
                state_next = start ? HOLD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_adder_controller.sv
// Bench for serial_adder_controller: a behavioural digit-serial datapath is
// driven by the controller strobes; expected sums go into a scoreboard queue
// at launch and are compared when done rises.
module tb_serial_adder_controller;

    logic clk;
    logic rst;
    logic start;
    logic loadA, loadB, zeroA, zeroB, zeroR, zeroD;
    logic enbA, enbB, enbR, loadR, done;

    serial_adder_controller #(.WIDTH(64), .DIGIT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .loadA (loadA),
        .loadB (loadB),
        .zeroA (zeroA),
        .zeroB (zeroB),
        .zeroR (zeroR),
        .zeroD (zeroD),
        .enbA  (enbA),
        .enbB  (enbB),
        .enbR  (enbR),
        .loadR (loadR),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] outs;
    assign outs = {loadA, loadB, zeroA, zeroB, zeroR, zeroD, enbA, enbB, enbR, loadR, done};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Behavioural datapath driven by the strobes
    logic [63:0] dA, dB;
    logic [63:0] ma, mb, mr;
    logic        mc;
    logic [4:0]  dsum;
    assign dsum = {1'b0, ma[3:0]} + {1'b0, mb[3:0]} + {4'b0, mc};

    // Datapath registers update on the strobes sampled at the clock edge.
    always @(posedge clk) begin
        if (zeroA) ma <= '0; else if (loadA) ma <= dA; else if (enbA) ma <= ma >> 4;
        if (zeroB) mb <= '0; else if (loadB) mb <= dB; else if (enbB) mb <= mb >> 4;
        if (zeroR) mr <= '0; else if (enbR) mr <= {dsum[3:0], mr[63:4]};
        if (zeroD) mc <= 1'b0; else if (loadR) mc <= dsum[4];
    end

    typedef struct {
        logic [63:0] sum;
        logic        carry;
    } exp_t;
    exp_t sb[$];

    int n_shift = 0;
    int n_init  = 0;
    int n_fin   = 0;
    int excl_viol = 0;
    logic done_q = 1'b0;

    // Strobe counting, exclusivity monitoring and scoreboard compare on done rise.
    always @(negedge clk) begin
        if (!rst) begin
            n_shift = 0;
            n_init  = 0;
            n_fin   = 0;
            done_q  = 1'b0;
        end else begin
            if (enbA)  n_shift++;
            if (loadA) n_init++;
            if (zeroA) n_fin++;
            if ($countones({loadA, zeroA, enbA}) > 1 ||
                $countones({loadB, zeroB, enbB}) > 1 ||
                $countones({zeroR, enbR}) > 1 ||
                $countones({zeroD, loadR}) > 1)
                excl_viol++;
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", mr, e.sum);
                    check("carry", {63'd0, mc}, {63'd0, e.carry});
                    check("shift_cycles", 64'(n_shift), 64'd16);
                    check("init_cycles", 64'(n_init), 64'd1);
                    check("finish_cycles", 64'(n_fin), 64'd1);
                end
                n_shift = 0;
                n_init  = 0;
                n_fin   = 0;
            end
            done_q = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        exp_t e;
        s = {1'b0, a} + {1'b0, b};
        e.sum   = s[63:0];
        e.carry = s[64];
        sb.push_back(e);
        dA    = a;
        dB    = b;
        start = 1'b1;
    endtask

    // Launch one addition and wait for done; keep=1 leaves start high.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input bit keep);
        int lat;
        bit got;
        launch(a, b);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            tick();
            lat = k;
            if (k == 1) begin
                check({tag, "_done_clr"}, {63'd0, done}, 64'd0);
                if (!keep) start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        if (got) check({tag, "_latency"}, 64'(lat), 64'd19);
        else     check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        dA    = '0;
        dB    = '0;

        // Reset
        #2 rst = 1'b0;
        #1 check("reset_outs", {53'd0, outs}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("idle_outs", {53'd0, outs}, 64'd0);

        // Single pulse
        run_op("single", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        tick();
        check("single_done_sticky", {63'd0, done}, 64'd1);
        check("single_idle_strobes", {53'd0, outs[10:1]}, 64'd0);

        // Held start: one addition only
        run_op("held", 64'h0000_0000_DEAD_BEEF, 64'h0000_0001_0000_0001, 1'b1);
        for (int k = 0; k < 21; k++) tick();
        check("held_no_relaunch", 64'(n_shift + n_init), 64'd0);
        check("held_done", {63'd0, done}, 64'd1);
        start = 1'b0;
        tick();
        tick();
        check("held_idle_done", {63'd0, done}, 64'd1);
        run_op("held2", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);

        // Back-to-back: one low cycle then restart
        start = 1'b0;
        tick();
        run_op("b2b", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        tick();

        // Mid-op reset at the 8th shift cycle
        launch(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
        for (int k = 1; k <= 30 && n_shift < 8; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        check("mid_shift_reached", 64'(n_shift), 64'd8);
        rst = 1'b0;
        #1 check("mid_reset_outs", {53'd0, outs}, 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_after_reset", {53'd0, outs}, 64'd0);
        run_op("restart", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5556, 1'b0);
        tick();

        // A few random additions
        for (int i = 0; i < 3; i++) begin
            run_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
            tick();
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        check("strobe_exclusive", 64'(excl_viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
